// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one external AS_N/WR_N/ACK_N bus between the CPU memory access
//   controller (port 0) and the debug/IO monitor (port 1). Round-robin on
//   ties, ACK routed back to the granted port only, address mux steering,
//   and a watchdog that aborts accesses to a slave that never answers.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   cpu_as_n/cpu_wr_n     CPU request strobe / direction (0 = write)
//   cpu_ack_n             ACK back to CPU
//   io_as_n/io_wr_n       IO-port request strobe / direction
//   io_ack_n              ACK back to IO port
//   bus_as_n/bus_wr_n     strobes to the bus (registered decode only)
//   bus_ack_n             ACK from the bus slave
//   addr_sel              address/data mux: 0 = CPU, 1 = IO
//   busy                  FSM is not IDLE
//   timeout_err           sticky watchdog-abort flag
//   state                 FSM state for the debug STATE bus
module bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_as_n,
  input  logic       cpu_wr_n,
  output logic       cpu_ack_n,
  input  logic       io_as_n,
  input  logic       io_wr_n,
  output logic       io_ack_n,
  output logic       bus_as_n,
  output logic       bus_wr_n,
  input  logic       bus_ack_n,
  output logic       addr_sel,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GCPU = 2'b01,
    GIO  = 2'b10,
    REL  = 2'b11
  } state_t;

  // one request per master; index 0 = CPU, 1 = IO
  typedef struct packed {
    logic as_n;
    logic wr_n;
  } req_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  req_t [1:0]      req;
  state_t          state_q, state_d;
  logic            last_q, last_d;   // port index of the most recent grant
  logic            wr_q, wr_d;       // captured direction of the granted port
  logic [TO_W-1:0] wdog_q, wdog_d;   // grant cycles already spent without ACK
  logic            err_q, err_d;
  logic            win;
  logic            granted;
  logic            wd_hit;
  logic            abort;
  logic            grant_ack_n;

  assign req[0] = '{as_n: cpu_as_n, wr_n: cpu_wr_n};
  assign req[1] = '{as_n: io_as_n,  wr_n: io_wr_n};

  assign granted = (state_q == GCPU) || (state_q == GIO);
  // wdog_q counts completed no-ACK grant cycles, so the current cycle is
  // grant cycle wdog_q+1; the abort lands in grant cycle TIMEOUT.
  assign wd_hit  = (wdog_q == WD_LAST);
  // a real ACK in the deadline cycle wins over the abort
  assign abort   = granted && bus_ack_n && wd_hit;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_d    = wr_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!req[0].as_n || !req[1].as_n) begin
          if (!req[0].as_n && !req[1].as_n) win = ~last_q;
          else                              win = req[0].as_n;
          last_d  = win;
          wr_d    = req[win].wr_n;
          wdog_d  = '0;
          state_d = win ? GIO : GCPU;
        end
      end
      GCPU, GIO: begin
        if (!bus_ack_n) begin
          state_d = REL;
        end else if (wd_hit) begin
          state_d = REL;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      REL: begin
        // wait for the granted master to drop its strobe so a stale
        // request is never re-granted
        if (req[last_q].as_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wr_q    <= 1'b1;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // ACK path is combinational from bus_ack_n; the abort forces it low
  assign grant_ack_n = bus_ack_n & ~abort;
  assign cpu_ack_n   = (state_q == GCPU) ? grant_ack_n : 1'b1;
  assign io_ack_n    = (state_q == GIO)  ? grant_ack_n : 1'b1;

  // strobes and status come from registered state only
  assign bus_as_n    = ~granted;
  assign bus_wr_n    = granted ? wr_q : 1'b1;
  assign addr_sel    = last_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign state       = state_q;

endmodule
